// File: rtl/axis_header_packer_pkg.sv
// rtl/axis_header_packer_pkg.sv - shared constants, FSM encoding and byte swap for the header packer
//
// Contents:
//   NUMBER_OF_HEADER_WORDS_DEFAULT - words per emitted block header
//   WORD_IDX_WIDTH                 - width of the header word index
//   state_t                        - PASS / DRAIN / PAD framing states
//   byte_swap32                    - little-endian wire word to big-endian SHA word
package axis_header_packer_pkg;

    localparam int NUMBER_OF_HEADER_WORDS_DEFAULT = 20;
    localparam int WORD_IDX_WIDTH                 = 5;

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/axis_header_packer_if.sv
// rtl/axis_header_packer_if.sv - stream bundle shared by the header packer input and output sides
//
// Signals: tvalid, tready, tdata, tstrb, tlast.
// Modports: master drives the beat and samples tready; slave the reverse.
interface axis_header_packer_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tstrb, input  tlast, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry stream buffer with registered input ready
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   - write side; in_ready is a register
//   out_valid/out_ready/out_data/out_last - read side, driven from the head entry
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int ENTRY_WIDTH = DATA_WIDTH + 1;

    logic [ENTRY_WIDTH-1:0] ent0_q;
    logic [ENTRY_WIDTH-1:0] ent1_q;
    logic [1:0]             count_q;
    logic [1:0]             count_d;
    logic [1:0]             wr_slot;
    logic                   push;
    logic                   pop;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = ent0_q[DATA_WIDTH-1:0];
    assign out_last  = ent0_q[DATA_WIDTH];

    always_comb begin
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        // Slot the new word lands in once the head has (possibly) moved on.
        wr_slot = count_q - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            in_ready <= 1'b0;
            ent0_q   <= '0;
            ent1_q   <= '0;
        end else begin
            count_q  <= count_d;
            // Ready only while a further word is guaranteed a slot next cycle.
            in_ready <= (count_d <= 2'd1);
            if (pop) begin
                ent0_q <= ent1_q;
            end
            // A push into slot 0 overrides the shift above (push+pop at one entry).
            if (push) begin
                if (wr_slot == 2'd0) begin
                    ent0_q <= {in_last, in_data};
                end else begin
                    ent1_q <= {in_last, in_data};
                end
            end
        end
    end

endmodule

// File: rtl/axis_header_packer.sv
// rtl/axis_header_packer.sv - frames raw DMA words into fixed-length byte-swapped block headers
//
// Ports:
//   s00_axis_aclk, s00_axis_aresetn - clock, asynchronous active-low reset
//   s00_axis (slave)                - raw little-endian header words from the DMA; tstrb ignored
//   m00_axis (master)               - big-endian header words to the miner, tlast on the final word
//   err_short                       - pulse: input packet ended before the header was full
//   err_long                        - pulse: first discarded word of an over-length packet
//   hdr_count                       - headers delivered (output tlast handshakes), wrapping
module axis_header_packer
    import axis_header_packer_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH   = 32,
    parameter int C_M_AXIS_TDATA_WIDTH   = 32,
    parameter int NUMBER_OF_HEADER_WORDS = NUMBER_OF_HEADER_WORDS_DEFAULT,
    parameter bit BYTE_SWAP              = 1'b1
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    axis_header_packer_if.slave   s00_axis,
    axis_header_packer_if.master  m00_axis,
    output logic                  err_short,
    output logic                  err_long,
    output logic [15:0]           hdr_count
);

    localparam logic [WORD_IDX_WIDTH-1:0] LAST_IDX = WORD_IDX_WIDTH'(NUMBER_OF_HEADER_WORDS - 1);

    state_t                            state_q;
    state_t                            state_d;
    logic [WORD_IDX_WIDTH-1:0]         word_idx_q;
    logic [WORD_IDX_WIDTH-1:0]         word_idx_d;
    logic                              drain_seen_q;
    logic                              drain_seen_d;
    logic                              err_short_d;
    logic                              err_long_d;
    logic                              buf_ready;
    logic                              push_valid;
    logic                              push_last;
    logic                              s_ready;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   push_data;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   in_word;
    logic                              out_valid;
    logic                              out_last;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   out_data;
    logic                              unused_tstrb;

    assign unused_tstrb    = ^s00_axis.tstrb;
    assign in_word         = BYTE_SWAP ? byte_swap32(s00_axis.tdata) : s00_axis.tdata;
    assign push_last       = (word_idx_q == LAST_IDX);
    assign s00_axis.tready = s_ready;

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        drain_seen_d = drain_seen_q;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        push_valid   = 1'b0;
        push_data    = '0;
        s_ready      = 1'b0;
        case (state_q)
            ST_PASS: begin
                s_ready    = buf_ready;
                push_valid = s00_axis.tvalid;
                push_data  = in_word;
                if (s00_axis.tvalid && buf_ready) begin
                    if (push_last) begin
                        word_idx_d = '0;
                        if (!s00_axis.tlast) begin
                            state_d      = ST_DRAIN;
                            drain_seen_d = 1'b0;
                        end
                    end else if (s00_axis.tlast) begin
                        word_idx_d  = word_idx_q + 1'b1;
                        err_short_d = 1'b1;
                        state_d     = ST_PAD;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Swallow the tail of an over-length packet without waiting on the miner.
                s_ready = 1'b1;
                if (s00_axis.tvalid) begin
                    err_long_d   = !drain_seen_q;
                    drain_seen_d = 1'b1;
                    if (s00_axis.tlast) begin
                        state_d = ST_PASS;
                    end
                end
            end
            ST_PAD: begin
                push_valid = 1'b1;
                if (buf_ready) begin
                    if (push_last) begin
                        word_idx_d = '0;
                        state_d    = ST_PASS;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q      <= ST_PASS;
            word_idx_q   <= '0;
            drain_seen_q <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            hdr_count    <= 16'd0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            drain_seen_q <= drain_seen_d;
            err_short    <= err_short_d;
            err_long     <= err_long_d;
            if (out_valid && m00_axis.tready && out_last) begin
                hdr_count <= hdr_count + 16'd1;
            end
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH)
    ) u_skid (
        .clk       (s00_axis_aclk),
        .rst_n     (s00_axis_aresetn),
        .in_valid  (push_valid),
        .in_ready  (buf_ready),
        .in_data   (push_data),
        .in_last   (push_last),
        .out_valid (out_valid),
        .out_ready (m00_axis.tready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    assign m00_axis.tvalid = out_valid;
    assign m00_axis.tdata  = out_data;
    assign m00_axis.tlast  = out_last;
    assign m00_axis.tstrb  = '1;

endmodule

// File: tb/tb_axis_header_packer.sv
// tb/tb_axis_header_packer.sv - directed self-checking bench for axis_header_packer
module tb_axis_header_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        err_short;
    logic        err_long;
    logic [15:0] hdr_count;

    int assertions = 0;
    int failures = 0;
    int cycle = 0;
    int rdy_mode = 0;
    int err_short_cnt = 0;
    int err_long_cnt = 0;
    int stall_viol = 0;

    logic [32:0] out_q[$];
    int          stamp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    axis_header_packer_if #(.DATA_WIDTH(32)) s_if ();
    axis_header_packer_if #(.DATA_WIDTH(32)) m_if ();

    axis_header_packer #(
        .C_S_AXIS_TDATA_WIDTH   (32),
        .C_M_AXIS_TDATA_WIDTH   (32),
        .NUMBER_OF_HEADER_WORDS (20),
        .BYTE_SWAP              (1'b1)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis         (s_if),
        .m00_axis         (m_if),
        .err_short        (err_short),
        .err_long         (err_long),
        .hdr_count        (hdr_count)
    );

    function automatic logic [31:0] swap_model(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
    endfunction

    // Miner-side ready: always high, or a coin flip per cycle.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_if.tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: records beats, error pulses and stall-stability violations.
    initial begin
        logic        prev_stall;
        logic [32:0] prev_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!m_if.tvalid || {m_if.tlast, m_if.tdata} != prev_beat)) stall_viol++;
                if (m_if.tvalid && m_if.tready) begin
                    out_q.push_back({m_if.tlast, m_if.tdata});
                    stamp_q.push_back(cycle);
                end
                if (err_short) err_short_cnt++;
                if (err_long) err_long_cnt++;
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_beat  = {m_if.tlast, m_if.tdata};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        logic hs;
        int   guard;
        hs = 1'b0;
        guard = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        while (!hs && guard < 500) begin
            @(negedge clk);
            hs = s_if.tready;
            @(posedge clk); #1;
            guard++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (!hs) begin
            assertions++; failures++;
            $display("FAIL send_word_timeout: tready=0 for %0d cycles, required 1", guard);
        end
    endtask

    task automatic wait_outputs(input int n);
        int guard;
        guard = 0;
        while (out_q.size() < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (out_q.size() < n) begin
            assertions++; failures++;
            $display("FAIL wait_outputs: got %0d beats, required %0d", out_q.size(), n);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_q.delete(); stamp_q.delete();
        err_short_cnt = 0; err_long_cnt = 0; stall_viol = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        assertions++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b, required 0", m_if.tvalid); end
        assertions++; if (s_if.tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b, required 0", s_if.tready); end
        assertions++; if (m_if.tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h, required 0", m_if.tdata); end
        assertions++; if (m_if.tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b, required 0", m_if.tlast); end
        assertions++; if (m_if.tstrb !== 4'hF) begin failures++; $display("FAIL reset_tstrb: got %h, required f", m_if.tstrb); end
        assertions++; if (err_short !== 1'b0 || err_long !== 1'b0) begin failures++; $display("FAIL reset_err: got %b%b, required 00", err_short, err_long); end
        assertions++; if (hdr_count !== 16'd0) begin failures++; $display("FAIL reset_hdr_count: got %0d, required 0", hdr_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        assertions++; if (s_if.tready !== 1'b0) begin failures++; $display("FAIL reset_ready_early: got %b, required 0", s_if.tready); end
        @(posedge clk); #1;
        assertions++; if (s_if.tready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise: got %b, required 1", s_if.tready); end
    endtask

    task automatic test_normal();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 20; i++)
            send_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, i == 19);
        wait_outputs(20);
        assertions++; if (out_q.size() != 20) begin failures++; $display("FAIL normal_beats: got %0d, required 20", out_q.size()); end
        assertions++; if (out_q.size() > 0 && out_q[0] !== {1'b0, 32'h00010203}) begin failures++; $display("FAIL normal_first: got %h, required 000010203", out_q[0]); end
        for (int i = 0; i < 20 && i < out_q.size(); i++) begin
            e = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            assertions++;
            if (out_q[i] !== {1'(i == 19), e}) begin failures++; $display("FAIL normal_word%0d: got %h, required %h", i, out_q[i], {1'(i == 19), e}); end
        end
        assertions++; if (hdr_count !== 16'd1) begin failures++; $display("FAIL normal_hdr_count: got %0d, required 1", hdr_count); end
        assertions++; if (err_short_cnt != 0 || err_long_cnt != 0) begin failures++; $display("FAIL normal_err: got short=%0d long=%0d, required 0 0", err_short_cnt, err_long_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] inw[$];
        logic [31:0] w;
        do_reset();
        for (int h = 0; h < 3; h++)
            for (int i = 0; i < 20; i++) begin
                w = {8'(h), 8'(i), 8'hA5, 8'(h + i)};
                inw.push_back(w);
                send_word(w, i == 19);
            end
        wait_outputs(60);
        assertions++; if (out_q.size() != 60) begin failures++; $display("FAIL b2b_beats: got %0d, required 60", out_q.size()); end
        for (int i = 0; i < 60 && i < out_q.size(); i++) begin
            assertions++;
            if (out_q[i] !== {1'((i % 20) == 19), swap_model(inw[i])}) begin failures++; $display("FAIL b2b_word%0d: got %h, required %h", i, out_q[i], {1'((i % 20) == 19), swap_model(inw[i])}); end
            assertions++;
            if (stamp_q[i] != stamp_q[0] + i) begin failures++; $display("FAIL b2b_gap%0d: got cycle %0d, required %0d", i, stamp_q[i], stamp_q[0] + i); end
        end
        assertions++; if (hdr_count !== 16'd3) begin failures++; $display("FAIL b2b_hdr_count: got %0d, required 3", hdr_count); end
    endtask

    task automatic test_short();
        logic [32:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) send_word(32'h11223300 + 32'(i), i == 4);
        wait_outputs(20);
        assertions++; if (err_short_cnt != 1) begin failures++; $display("FAIL short5_err: got %0d pulses, required 1", err_short_cnt); end
        send_word(32'hDEADBEEF, 1'b1);
        wait_outputs(40);
        assertions++; if (out_q.size() != 40) begin failures++; $display("FAIL short_beats: got %0d, required 40", out_q.size()); end
        for (int i = 0; i < 40 && i < out_q.size(); i++) begin
            if (i < 5) e = {1'b0, 8'(i), 24'h332211};
            else if (i == 20) e = {1'b0, 32'hEFBEADDE};
            else e = {1'((i % 20) == 19), 32'h0};
            assertions++;
            if (out_q[i] !== e) begin failures++; $display("FAIL short_word%0d: got %h, required %h", i, out_q[i], e); end
        end
        assertions++; if (err_short_cnt != 2) begin failures++; $display("FAIL short1_err: got %0d pulses, required 2", err_short_cnt); end
        assertions++; if (err_long_cnt != 0) begin failures++; $display("FAIL short_err_long: got %0d, required 0", err_long_cnt); end
        assertions++; if (hdr_count !== 16'd2) begin failures++; $display("FAIL short_hdr_count: got %0d, required 2", hdr_count); end
    endtask

    task automatic test_long();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 23; i++) send_word({8'(i), 8'h55, 8'(i), 8'hC0}, i == 22);
        for (int i = 0; i < 20; i++) send_word({8'(i), 8'h66, 8'(i), 8'hD1}, i == 19);
        wait_outputs(40);
        repeat (4) @(posedge clk);
        #1;
        assertions++; if (out_q.size() != 40) begin failures++; $display("FAIL long_beats: got %0d, required 40", out_q.size()); end
        for (int i = 0; i < 40 && i < out_q.size(); i++) begin
            e = (i < 20) ? {8'hC0, 8'(i), 8'h55, 8'(i)} : {8'hD1, 8'(i - 20), 8'h66, 8'(i - 20)};
            assertions++;
            if (out_q[i] !== {1'((i % 20) == 19), e}) begin failures++; $display("FAIL long_word%0d: got %h, required %h", i, out_q[i], {1'((i % 20) == 19), e}); end
        end
        assertions++; if (err_long_cnt != 1) begin failures++; $display("FAIL long_err_long: got %0d pulses, required 1", err_long_cnt); end
        assertions++; if (err_short_cnt != 0) begin failures++; $display("FAIL long_err_short: got %0d, required 0", err_short_cnt); end
        assertions++; if (hdr_count !== 16'd2) begin failures++; $display("FAIL long_hdr_count: got %0d, required 2", hdr_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] inw[$];
        logic [31:0] w;
        do_reset();
        rdy_mode = 1;
        for (int h = 0; h < 10; h++)
            for (int i = 0; i < 20; i++) begin
                w = $urandom;
                inw.push_back(w);
                send_word(w, i == 19);
            end
        wait_outputs(200);
        rdy_mode = 0;
        @(posedge clk); #1;
        assertions++; if (out_q.size() != 200) begin failures++; $display("FAIL bp_beats: got %0d, required 200", out_q.size()); end
        for (int i = 0; i < 200 && i < out_q.size(); i++) begin
            assertions++;
            if (out_q[i] !== {1'((i % 20) == 19), swap_model(inw[i])}) begin failures++; $display("FAIL bp_word%0d: got %h, required %h", i, out_q[i], {1'((i % 20) == 19), swap_model(inw[i])}); end
        end
        assertions++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stalls, required 0", stall_viol); end
        assertions++; if (hdr_count !== 16'd10) begin failures++; $display("FAIL bp_hdr_count: got %0d, required 10", hdr_count); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) send_word(32'hAB000000 | 32'(i), 1'b0);
        assertions++; if (m_if.tvalid !== 1'b1) begin failures++; $display("FAIL mid_inflight: got tvalid %b, required 1", m_if.tvalid); end
        rst_n = 1'b0;
        #1;
        assertions++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid_drop: got %b, required 0", m_if.tvalid); end
        assertions++; if (s_if.tready !== 1'b0) begin failures++; $display("FAIL mid_tready_drop: got %b, required 0", s_if.tready); end
        @(posedge clk); #1;
        out_q.delete(); stamp_q.delete();
        err_short_cnt = 0; err_long_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) send_word({8'(i), 8'h77, 8'h00, 8'(i + 1)}, i == 19);
        wait_outputs(20);
        assertions++; if (out_q.size() != 20) begin failures++; $display("FAIL mid_beats: got %0d, required 20", out_q.size()); end
        for (int i = 0; i < 20 && i < out_q.size(); i++) begin
            e = {8'(i + 1), 8'h00, 8'h77, 8'(i)};
            assertions++;
            if (out_q[i] !== {1'(i == 19), e}) begin failures++; $display("FAIL mid_word%0d: got %h, required %h", i, out_q[i], {1'(i == 19), e}); end
        end
        assertions++; if (hdr_count !== 16'd1) begin failures++; $display("FAIL mid_hdr_count: got %0d, required 1", hdr_count); end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'h0;
        s_if.tstrb  = 4'h0;
        s_if.tlast  = 1'b0;
        #2;
        test_reset();
        test_normal();
        test_back_to_back();
        test_short();
        test_long();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
